// File: rtl/button_conditioner.sv
// Multi-channel push-button/switch conditioner: synchroniser, debounce FSM,
// registered rise/fall pulses and a press-toggled state per input bit.
module button_conditioner #(
    parameter int               WIDTH           = 2,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] TOGGLE_INIT     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall,
    output logic [WIDTH-1:0] btn_toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE,
        COUNTING
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            state_t                 state_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   level_reg;
            logic                   rise_reg;
            logic                   fall_reg;
            logic                   toggle_reg;

            assign s = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg   <= '0;
                    state_reg  <= STABLE;
                    cnt_reg    <= '0;
                    level_reg  <= 1'b0;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                    toggle_reg <= TOGGLE_INIT[gi];
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    case (state_reg)
                        STABLE: begin
                            if (s != level_reg) begin
                                if (DEBOUNCE_CYCLES == 1) begin
                                    level_reg  <= s;
                                    rise_reg   <= s;
                                    fall_reg   <= ~s;
                                    toggle_reg <= toggle_reg ^ s;
                                end else begin
                                    state_reg <= COUNTING;
                                    cnt_reg   <= CNT_W'(1);
                                end
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        COUNTING: begin
                            // Any sample matching the current level restarts the qualification.
                            if (s == level_reg) begin
                                state_reg <= STABLE;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_LAST) begin
                                level_reg  <= s;
                                rise_reg   <= s;
                                fall_reg   <= ~s;
                                toggle_reg <= toggle_reg ^ s;
                                state_reg  <= STABLE;
                                cnt_reg    <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= STABLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]  = level_reg;
            assign btn_rise[gi]   = rise_reg;
            assign btn_fall[gi]   = fall_reg;
            assign btn_toggle[gi] = toggle_reg;
        end
    endgenerate

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for board-level demo designs such as the LED up/down counter.
- Takes raw, asynchronous, bouncing push-button and switch inputs and delivers clean, clk-synchronous signals:
  - debounced level
  - single-cycle rise and fall pulses
  - press-toggled state
- Its outputs drive the counter's rst and direction inputs directly. Multi-channel, one independent instance of the logic per bit.

Parameters:
- WIDTH, 2: number of independent input channels.
- SYNC_STAGES, 2: flops in each synchroniser chain; legal range >= 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the level changes (10 ms at 100 MHz); legal range >= 1.
- TOGGLE_INIT, 0: per-channel reset value of btn_toggle; WIDTH bits; bit i applies to channel i.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- btn_raw, in, WIDTH: raw asynchronous pad inputs; 1 = pressed/on.
- btn_level, out, WIDTH: debounced level.
- btn_rise, out, WIDTH: one-cycle pulse on each debounced 0->1 transition.
- btn_fall, out, WIDTH: one-cycle pulse on each debounced 1->0 transition.
- btn_toggle, out, WIDTH: inverts on every btn_rise.

Behaviour:
- **Channel independence:** all channels are identical and independent. No cross-channel state is shared.
- **Synchroniser:**
  - btn_raw[i] enters a SYNC_STAGES-deep flop chain; s[i] is the last stage.
  - A raw change first sampled at edge k appears on s at edge k+SYNC_STAGES-1.
  - The synchroniser is the only logic that touches btn_raw.
- **Debounce FSM per channel:** two states, STABLE and COUNTING, plus a counter of width clog2(DEBOUNCE_CYCLES+1).
  - STABLE, s == level: hold; cnt = 0.
  - STABLE, s != level:
    - If DEBOUNCE_CYCLES == 1, update level at this edge.
    - Otherwise go to COUNTING with cnt = 1.
  - COUNTING, s == level: bounce rejected. Return to STABLE, cnt = 0, no output change.
  - COUNTING, s != level, cnt == DEBOUNCE_CYCLES-1: level <= s, go to STABLE, cnt = 0.
  - COUNTING, otherwise: cnt++.
  - Net effect: level changes at the edge where s has differed from level for DEBOUNCE_CYCLES consecutive sampled cycles.
  - End-to-end latency: the level changes at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES, with k the first sampling edge.
  - The counter never wraps, because it saturates by construction at DEBOUNCE_CYCLES-1.
- **Pulses:**
  - btn_rise/btn_fall are registered. They are high for exactly the one cycle following the edge at which level changes, i.e. concurrent with the new level.
  - They are never asserted together on one channel.
  - Back-to-back pulses on a channel are at least DEBOUNCE_CYCLES cycles apart.
- **Toggle:** btn_toggle[i] inverts at the same edge that sets btn_rise[i]. Release (fall) does not affect it.
- **Reset** (synchronous, active-high; dominates all other activity, including mid-count):
  - sync chain = 0, level = 0, cnt = 0, state = STABLE
  - rise = 0, fall = 0, toggle = TOGGLE_INIT
- **After reset:**
  - If btn_raw is held at 1 across reset release, a btn_rise and toggle flip occur at the normal latency after release. This is intended: level restarts from 0.
  - No pulses are emitted while rst is high.
- **Timing:** all outputs are driven directly from flops, with no combinational path from btn_raw to any output.

Test Plan (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TOGGLE_INIT=2'b00):
1. **Reset values:** hold rst 3 cycles with btn_raw=2'b00 -> level=00, rise=00, fall=00, toggle=00 at every cycle during and after reset.
2. **Clean press:** raw[0] 0->1 first sampled at edge k and held -> level[0]=1 and rise[0]=1 after edge k+5; rise[0] back to 0 after edge k+6; toggle[0]=1; channel 1 unchanged.
3. **Bounce rejection:** raw[0] pattern 1,1,1,0,1,1,0 per cycle -> no level change, no pulses. Then hold 1 -> rise[0] exactly 5 edges after the final 0->1 sample.
4. **Release and second press:** release from scenario 2 -> fall[0] 1 cycle, toggle stays 1. Press again -> rise[0], toggle[0]=0.
5. **Reset mid-count:** raw[1]=1; assert rst at edge k+3 for 1 cycle -> cnt cleared, level[1]=0, no rise. Rise[1] appears 5 edges after the first post-reset sampling edge.
6. **Independent simultaneous channels:** raw=2'b11 same edge -> rise=2'b11 same cycle. raw[1] bounces while raw[0] is stable -> only channel 1 affected.
